// File: rtl/wav_apb_req_master.sv
// Request/response to APB3 master bridge with one outstanding transfer.
// A PREADY timeout and a saturating error counter keep a hung slave observable.
module wav_apb_req_master #(
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_W      = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  RegClk,
  input  logic                  RegReset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic [7:0]            err_count,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]           PWDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  input  logic [31:0]           PRDATA
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST =
    TIMEOUT_W'(TIMEOUT_EN ? TIMEOUT_CYCLES - 1 : 0);

  state_t               state;
  logic [TIMEOUT_W-1:0] wait_cnt;
  logic                 timed_out;
  logic                 finish;

  // Abort fires on the last allowed ACCESS cycle; PREADY in that same cycle still wins.
  assign timed_out = TIMEOUT_EN && (wait_cnt == TIMEOUT_LAST);
  assign finish    = PREADY || timed_out;

  always_ff @(posedge RegClk) begin
    if (RegReset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      err_count   <= '0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            PWRITE    <= req_write;
            PADDR     <= req_addr;
            PWDATA    <= req_wdata;
            PSEL      <= 1'b1;
            req_ready <= 1'b0;
            state     <= SETUP;
          end else begin
            req_ready <= 1'b1;
          end
        end
        SETUP: begin
          PENABLE  <= 1'b1;
          wait_cnt <= '0;
          state    <= ACCESS;
        end
        ACCESS: begin
          if (finish) begin
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_timeout <= !PREADY;
            rsp_err     <= PREADY ? PSLVERR : 1'b1;
            rsp_rdata   <= (PREADY && !PWRITE) ? PRDATA : '0;
            if ((!PREADY || PSLVERR) && (err_count != 8'hFF)) begin
              err_count <= err_count + 8'd1;
            end
            state <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wav_apb_req_master.sv
// Bench for wav_apb_req_master: directed vector table, random transfers against a
// rule-level model, reset/hold/saturation sequences, and a timeout-disabled instance.
module tb_wav_apb_req_master;

  localparam int T = 4;

  logic        RegClk = 1'b0;
  logic        RegReset;
  logic        req_valid, req_ready, req_write;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err, rsp_timeout;
  logic [7:0]  err_count;
  logic        PSEL, PENABLE, PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic        PREADY, PSLVERR;
  logic [31:0] PRDATA;

  logic        req_valid_z, req_ready_z, req_write_z;
  logic [7:0]  req_addr_z;
  logic [31:0] req_wdata_z;
  logic        rsp_valid_z, rsp_ready_z;
  logic [31:0] rsp_rdata_z;
  logic        rsp_err_z, rsp_timeout_z;
  logic [7:0]  err_count_z;
  logic        PSEL_z, PENABLE_z, PWRITE_z;
  logic [7:0]  PADDR_z;
  logic [31:0] PWDATA_z;
  logic        PREADY_z, PSLVERR_z;
  logic [31:0] PRDATA_z;

  int total = 0;
  int bad   = 0;
  int exp_errs = 0;

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          ready_at;
    logic        slverr;
    logic [31:0] prdata;
    int          hold;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_to;
  } vec_t;

  vec_t vecs[8];

  always #5 RegClk = ~RegClk;

  wav_apb_req_master #(.ADDR_WIDTH(8), .TIMEOUT_W(8), .TIMEOUT_CYCLES(T)) dut (
    .RegClk(RegClk), .RegReset(RegReset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .err_count(err_count),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
  );

  wav_apb_req_master #(.ADDR_WIDTH(8), .TIMEOUT_W(8), .TIMEOUT_CYCLES(0)) dut_z (
    .RegClk(RegClk), .RegReset(RegReset),
    .req_valid(req_valid_z), .req_ready(req_ready_z), .req_write(req_write_z),
    .req_addr(req_addr_z), .req_wdata(req_wdata_z),
    .rsp_valid(rsp_valid_z), .rsp_ready(rsp_ready_z), .rsp_rdata(rsp_rdata_z),
    .rsp_err(rsp_err_z), .rsp_timeout(rsp_timeout_z), .err_count(err_count_z),
    .PSEL(PSEL_z), .PENABLE(PENABLE_z), .PWRITE(PWRITE_z), .PADDR(PADDR_z), .PWDATA(PWDATA_z),
    .PREADY(PREADY_z), .PSLVERR(PSLVERR_z), .PRDATA(PRDATA_z)
  );

  task automatic tick();
    @(posedge RegClk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                              input int ready_at, input logic slverr, input logic [31:0] prdata,
                              input int hold, input logic [31:0] exp_rdata, input logic exp_err,
                              input logic exp_to);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.ready_at = ready_at; v.slverr = slverr;
    v.prdata = prdata; v.hold = hold; v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_to = exp_to;
    return v;
  endfunction

  // Reference: a slave that answers later than T access cycles means abort.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    r.exp_to    = (v.ready_at >= T);
    r.exp_err   = r.exp_to || v.slverr;
    r.exp_rdata = (!r.exp_to && !v.wr) ? v.prdata : 32'h0;
    return r;
  endfunction

  task automatic applyStimulus(input vec_t v);
    int          n_access;
    logic [31:0] held_rdata;
    n_access = (v.ready_at < T) ? v.ready_at + 1 : T;
    for (int w = 0; w < 20 && req_ready !== 1'b1; w++) tick();
    checkOutput("idle_req_ready", req_ready, 1);
    req_valid = 1'b1; req_write = v.wr; req_addr = v.addr; req_wdata = v.wdata;
    tick();
    req_valid = 1'b0; req_write = 1'($urandom); req_addr = 8'($urandom); req_wdata = $urandom;
    checkOutput("setup_psel_penable", {PSEL, PENABLE}, 2'b10);
    checkOutput("setup_paddr", PADDR, v.addr);
    checkOutput("setup_pwrite", PWRITE, v.wr);
    checkOutput("setup_pwdata", PWDATA, v.wdata);
    checkOutput("setup_req_ready", req_ready, 0);
    checkOutput("setup_rsp_valid", rsp_valid, 0);
    tick();
    for (int k = 0; k < n_access; k++) begin
      checkOutput("access_psel_penable", {PSEL, PENABLE}, 2'b11);
      checkOutput("access_rsp_valid", rsp_valid, 0);
      PREADY = (k == v.ready_at); PSLVERR = v.slverr; PRDATA = v.prdata;
      tick();
      PREADY = 1'b0; PSLVERR = 1'($urandom); PRDATA = $urandom;
    end
    if (v.exp_err && exp_errs < 255) exp_errs++;
    checkOutput("resp_rsp_valid", rsp_valid, 1);
    checkOutput("resp_psel_penable", {PSEL, PENABLE}, 2'b00);
    checkOutput("resp_rdata", rsp_rdata, v.exp_rdata);
    checkOutput("resp_err", rsp_err, v.exp_err);
    checkOutput("resp_timeout", rsp_timeout, v.exp_to);
    checkOutput("resp_err_count", err_count, exp_errs);
    checkOutput("resp_req_ready", req_ready, 0);
    held_rdata = rsp_rdata;
    for (int h = 0; h < v.hold; h++) begin
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_write = 1'($urandom); req_addr = 8'($urandom); req_wdata = $urandom;
      tick();
      checkOutput("hold_rsp_valid", rsp_valid, 1);
      checkOutput("hold_rdata", rsp_rdata, held_rdata);
      checkOutput("hold_err_timeout", {rsp_err, rsp_timeout}, {v.exp_err, v.exp_to});
      checkOutput("hold_req_ready", req_ready, 0);
      checkOutput("hold_psel", PSEL, 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput("done_rsp_valid", rsp_valid, 0);
    checkOutput("done_req_ready", req_ready, 1);
    checkOutput("done_psel", PSEL, 0);
    checkOutput("done_paddr_held", PADDR, v.addr);
    checkOutput("done_pwrite_held", PWRITE, v.wr);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   miss;
    vec_t v;
    vecs[0] = mk(1'b1, 8'h00, 32'h0000001F, 0,    1'b0, 32'hDEADBEEF, 0,  32'h0,        1'b0, 1'b0);
    vecs[1] = mk(1'b0, 8'h08, 32'h0,        0,    1'b0, 32'h0000001F, 0,  32'h1F,       1'b0, 1'b0);
    vecs[2] = mk(1'b0, 8'h0C, 32'h0,        0,    1'b1, 32'h0,        0,  32'h0,        1'b1, 1'b0);
    vecs[3] = mk(1'b0, 8'h10, 32'h0,        1000, 1'b0, 32'h12345678, 0,  32'h0,        1'b1, 1'b1);
    vecs[4] = mk(1'b0, 8'h14, 32'h0,        3,    1'b0, 32'hA5A50001, 0,  32'hA5A50001, 1'b0, 1'b0);
    vecs[5] = mk(1'b1, 8'h20, 32'hCAFEF00D, 2,    1'b0, 32'h00000055, 10, 32'h0,        1'b0, 1'b0);
    vecs[6] = mk(1'b1, 8'h24, 32'h00000777, 1,    1'b1, 32'h00000077, 2,  32'h0,        1'b1, 1'b0);
    vecs[7] = mk(1'b0, 8'h28, 32'h0,        4,    1'b0, 32'h00000099, 0,  32'h0,        1'b1, 1'b1);

    RegReset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
    req_valid_z = 1'b0; req_write_z = 1'b0; req_addr_z = '0; req_wdata_z = '0; rsp_ready_z = 1'b0;
    PREADY_z = 1'b0; PSLVERR_z = 1'b0; PRDATA_z = '0;
    tick();
    tick();
    checkOutput("reset_req_ready", req_ready, 0);
    checkOutput("reset_rsp", {rsp_valid, rsp_err, rsp_timeout}, 3'b000);
    checkOutput("reset_rdata", rsp_rdata, 0);
    checkOutput("reset_err_count", err_count, 0);
    checkOutput("reset_apb_ctrl", {PSEL, PENABLE, PWRITE}, 3'b000);
    checkOutput("reset_paddr", PADDR, 0);
    checkOutput("reset_pwdata", PWDATA, 0);
    RegReset = 1'b0;

    $display("[TB] directed vector table");
    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

    $display("[TB] reset during ACCESS");
    for (int w = 0; w < 20 && req_ready !== 1'b1; w++) tick();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h30; req_wdata = 32'h0;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    checkOutput("pre_reset_access", {PSEL, PENABLE}, 2'b11);
    RegReset = 1'b1;
    tick();
    checkOutput("midreset_apb", {PSEL, PENABLE}, 2'b00);
    checkOutput("midreset_rsp_valid", rsp_valid, 0);
    checkOutput("midreset_err_count", err_count, 0);
    checkOutput("midreset_req_ready", req_ready, 0);
    RegReset = 1'b0;
    exp_errs = 0;
    applyStimulus(mk(1'b0, 8'h04, 32'h0, 1, 1'b0, 32'h600DF00D, 0, 32'h600DF00D, 1'b0, 1'b0));

    $display("[TB] random transfers");
    for (int i = 0; i < 40; i++) begin
      v.wr = 1'($urandom); v.addr = 8'($urandom); v.wdata = $urandom;
      v.ready_at = int'($urandom_range(0, 6)); v.slverr = 1'($urandom);
      v.prdata = $urandom; v.hold = int'($urandom_range(0, 3));
      applyStimulus(model(v));
    end

    $display("[TB] error counter saturation");
    for (int i = 0; i < 300; i++) begin
      v.wr = 1'b0; v.addr = 8'h0C; v.wdata = '0; v.ready_at = 0; v.slverr = 1'b1;
      v.prdata = $urandom; v.hold = 0;
      applyStimulus(model(v));
    end
    checkOutput("err_count_saturated", err_count, 8'hFF);

    $display("[TB] timeout disabled instance");
    for (int w = 0; w < 20 && req_ready_z !== 1'b1; w++) tick();
    checkOutput("z_req_ready", req_ready_z, 1);
    req_valid_z = 1'b1; req_write_z = 1'b0; req_addr_z = 8'h40;
    tick();
    req_valid_z = 1'b0;
    tick();
    miss = 0;
    for (int c = 0; c < 1100; c++) begin
      if (!(PSEL_z === 1'b1 && PENABLE_z === 1'b1 && rsp_valid_z === 1'b0)) miss++;
      tick();
    end
    checkOutput("z_access_held_bad_cycles", miss, 0);
    PREADY_z = 1'b1; PRDATA_z = 32'h13579BDF;
    tick();
    PREADY_z = 1'b0;
    checkOutput("z_rsp_valid", rsp_valid_z, 1);
    checkOutput("z_rsp_err_timeout", {rsp_err_z, rsp_timeout_z}, 2'b00);
    checkOutput("z_rsp_rdata", rsp_rdata_z, 32'h13579BDF);
    rsp_ready_z = 1'b1;
    tick();
    rsp_ready_z = 1'b0;
    checkOutput("z_done", {rsp_valid_z, req_ready_z}, 2'b01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
